// File: rtl/median_line_buffer.sv
// median_line_buffer: 3-row sliding column window for a streaming raster.
// Two line memories hold the previous two rows. Each accepted pixel produces
// one registered window column {two rows up, one row up, current}, one clock
// after the transfer.
//
// Optional feature macro: MEDIAN_BORDER_REPL_EN
//   defined   -> rows 0 and 1 replicate the nearest real row into the missing
//                window taps.
//   undefined -> missing taps in rows 0 and 1 read as zero, and no replication
//                logic is built.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready may depend combinationally on the downstream ready.
// Valid, once raised, holds with stable payload until that transfer.
module median_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LINE_W = 640,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  pix_val,
  output logic                  pix_rdy,
  input  logic                  pix_sol,
  input  logic                  pix_eol,
  input  logic                  pix_sof,
  input  logic                  pix_eof,
  output logic [DATA_WIDTH-1:0] win_pix0,
  output logic [DATA_WIDTH-1:0] win_pix1,
  output logic [DATA_WIDTH-1:0] win_pix2,
  output logic                  win_val,
  input  logic                  win_rdy,
  output logic                  win_sol,
  output logic                  win_eol,
  output logic                  win_sof,
  output logic                  win_eof,
  output logic                  err_ovf
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(MAX_LINE_W - 1);

  // Line memories: line0 is two rows up, line1 is one row up. They have no reset.
  logic [DATA_WIDTH-1:0] line0_mem [MAX_LINE_W];
  logic [DATA_WIDTH-1:0] line1_mem [MAX_LINE_W];

  logic                  acc;
  logic [ADDR_W-1:0]     cur_col;
  logic [1:0]            cur_row;
  logic [DATA_WIDTH-1:0] rd0, rd1;
  logic [DATA_WIDTH-1:0] tap0, tap1;

  logic [ADDR_W-1:0]     col_d, col_q;
  logic [1:0]            row_d, row_q;
  logic                  err_d, err_q;
  logic                  win_val_d, win_val_q;
  logic [DATA_WIDTH-1:0] win_pix0_d, win_pix0_q;
  logic [DATA_WIDTH-1:0] win_pix1_d, win_pix1_q;
  logic [DATA_WIDTH-1:0] win_pix2_d, win_pix2_q;
  logic [3:0]            win_mk_d, win_mk_q;  // {sof, eof, sol, eol}

  // The input side stalls exactly when the window register is stalled.
  assign pix_rdy = win_rdy;
  assign acc     = pix_val & pix_rdy;

  // The start-of-line and start-of-frame markers apply to the pixel that carries them.
  assign cur_col = pix_sol ? '0 : col_q;
  assign cur_row = pix_sof ? 2'd0 : row_q;
  assign rd0     = line0_mem[cur_col];
  assign rd1     = line1_mem[cur_col];

  // Select the upper window taps. Rows 0 and 1 have no real data above them.
  always_comb begin
    tap0 = rd0;
    tap1 = rd1;
`ifdef MEDIAN_BORDER_REPL_EN
    if (cur_row == 2'd0) begin
      tap0 = pix_data;
      tap1 = pix_data;
    end else if (cur_row == 2'd1) begin
      tap0 = rd1;
      tap1 = rd1;
    end
`else
    if (cur_row == 2'd0) begin
      tap0 = '0;
      tap1 = '0;
    end else if (cur_row == 2'd1) begin
      tap0 = '0;
    end
`endif
  end

  // Next-state logic for the position counters, the overflow flag and the window.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    err_d      = err_q;
    win_val_d  = win_val_q;
    win_pix0_d = win_pix0_q;
    win_pix1_d = win_pix1_q;
    win_pix2_d = win_pix2_q;
    win_mk_d   = win_mk_q;
    if (acc) begin
      // The last column always wraps. It counts as an overflow only when eol is missing.
      col_d = (cur_col == LAST_COL) ? '0 : cur_col + ADDR_W'(1);
      row_d = cur_row;
      if (pix_eol && cur_row != 2'd2) row_d = cur_row + 2'd1;
      err_d = (pix_sof ? 1'b0 : err_q) | ((cur_col == LAST_COL) & ~pix_eol);
      win_val_d  = 1'b1;
      win_pix0_d = tap0;
      win_pix1_d = tap1;
      win_pix2_d = pix_data;
      win_mk_d   = {pix_sof, pix_eof, pix_sol, pix_eol};
    end else if (win_rdy && !pix_val) begin
      win_val_d = 1'b0;
    end
  end

  // Control and window registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= 2'd0;
      err_q      <= 1'b0;
      win_val_q  <= 1'b0;
      win_pix0_q <= '0;
      win_pix1_q <= '0;
      win_pix2_q <= '0;
      win_mk_q   <= 4'd0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      err_q      <= err_d;
      win_val_q  <= win_val_d;
      win_pix0_q <= win_pix0_d;
      win_pix1_q <= win_pix1_d;
      win_pix2_q <= win_pix2_d;
      win_mk_q   <= win_mk_d;
    end
  end

  // Shift the column down one line. The old contents are read in the same cycle as the write.
  always_ff @(posedge clk) begin
    if (acc) begin
      line0_mem[cur_col] <= rd1;
      line1_mem[cur_col] <= pix_data;
    end
  end

  assign win_pix0 = win_pix0_q;
  assign win_pix1 = win_pix1_q;
  assign win_pix2 = win_pix2_q;
  assign win_val  = win_val_q;
  assign win_sof  = win_mk_q[3];
  assign win_eof  = win_mk_q[2];
  assign win_sol  = win_mk_q[1];
  assign win_eol  = win_mk_q[0];
  assign err_ovf  = err_q;

endmodule

// File: tb/tb_median_line_buffer.sv
// tb_median_line_buffer: scoreboard bench for median_line_buffer.
// The main instance uses the default parameters. A second instance with
// MAX_LINE_W=4 exercises line overflow. The test pattern gives pixel (r,c) the
// value 10*(r+1)+c, so each expected window column is computed directly from
// the frame geometry.
module tb_median_line_buffer;

`ifdef MEDIAN_BORDER_REPL_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic       clk, rst_n;
  logic [7:0] pix_data;
  logic       pix_val, pix_rdy, pix_sol, pix_eol, pix_sof, pix_eof;
  logic [7:0] win_pix0, win_pix1, win_pix2;
  logic       win_val, win_rdy, win_sol, win_eol, win_sof, win_eof, err_ovf;

  logic [7:0] o_pix_data;
  logic       o_pix_val, o_pix_rdy, o_pix_sol, o_pix_eol, o_pix_sof, o_pix_eof;
  logic [7:0] o_win_pix0, o_win_pix1, o_win_pix2;
  logic       o_win_val, o_win_sol, o_win_eol, o_win_sof, o_win_eof, o_err_ovf;
  logic       o_win_rdy;

  int n_checks = 0;
  int n_pass   = 0;

  // Each entry is {pix0, pix1, pix2, sof, eof, sol, eol}.
  logic [27:0] exp_q[$];

  median_line_buffer u_dut (
    .clk(clk), .rst_n(rst_n), .pix_data(pix_data), .pix_val(pix_val), .pix_rdy(pix_rdy),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .win_pix0(win_pix0), .win_pix1(win_pix1), .win_pix2(win_pix2), .win_val(win_val),
    .win_rdy(win_rdy), .win_sol(win_sol), .win_eol(win_eol), .win_sof(win_sof),
    .win_eof(win_eof), .err_ovf(err_ovf)
  );

  median_line_buffer #(.DATA_WIDTH(8), .MAX_LINE_W(4), .ADDR_W(2)) u_ovf (
    .clk(clk), .rst_n(rst_n), .pix_data(o_pix_data), .pix_val(o_pix_val), .pix_rdy(o_pix_rdy),
    .pix_sol(o_pix_sol), .pix_eol(o_pix_eol), .pix_sof(o_pix_sof), .pix_eof(o_pix_eof),
    .win_pix0(o_win_pix0), .win_pix1(o_win_pix1), .win_pix2(o_win_pix2), .win_val(o_win_val),
    .win_rdy(o_win_rdy), .win_sol(o_win_sol), .win_eol(o_win_eol), .win_sof(o_win_sof),
    .win_eof(o_win_eof), .err_ovf(o_err_ovf)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every window transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && win_val && win_rdy) begin
      logic [27:0] got, exp;
      got = {win_pix0, win_pix1, win_pix2, win_sof, win_eof, win_sol, win_eol};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL window_unexpected got=%h required=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got === exp) n_pass++;
        else $display("FAIL window got=%h required=%h", got, exp);
      end
    end
  end

  // Drive one pixel, wait (bounded) for its transfer, then check the one-clock latency.
  task automatic drive_pix(input logic [7:0] d, input bit sof, input bit eof, input bit sol,
                           input bit eol, input logic [7:0] e0, input logic [7:0] e1);
    int  waits;
    bit  ok;
    pix_data = d; pix_sof = sof; pix_eof = eof; pix_sol = sol; pix_eol = eol; pix_val = 1'b1;
    exp_q.push_back({e0, e1, d, sof, eof, sol, eol});
    ok = 1'b0;
    for (waits = 0; waits < 50 && !ok; waits++) begin
      @(negedge clk);
      ok = pix_rdy;
    end
    n_checks++;
    if (!ok) begin
      $display("FAIL pix_rdy_timeout got=0 required=1");
      return;
    end
    @(posedge clk); #1;
    if (win_val === 1'b1) n_pass++;
    else $display("FAIL latency win_val got=%b required=1", win_val);
  endtask

  // Send one line of row r with the expected window derived from the frame pattern.
  task automatic send_line(input int r, input int ncols, input bit first_sof, input bit last_eof);
    for (int c = 0; c < ncols; c++) begin
      logic [7:0] v, e0, e1;
      v  = 8'(10 * (r + 1) + c);
      e1 = (r >= 1) ? v - 8'd10 : (REPL ? v : 8'd0);
      e0 = (r >= 2) ? v - 8'd20 : (REPL ? ((r == 0) ? v : v - 8'd10) : 8'd0);
      drive_pix(v, first_sof && c == 0, last_eof && c == ncols - 1, c == 0, c == ncols - 1, e0, e1);
    end
  endtask

  task automatic go_idle();
    pix_val = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0; pix_sol = 1'b0; pix_eol = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; win_rdy = 1'b0; go_idle(); pix_data = 8'd0;
    o_pix_val = 1'b0; o_pix_data = 8'd0; o_win_rdy = 1'b1;
    o_pix_sol = 1'b0; o_pix_eol = 1'b0; o_pix_sof = 1'b0; o_pix_eof = 1'b0;
    #2;
    n_checks++;
    if ({win_val, win_sof, win_eof, win_sol, win_eol, err_ovf} === 6'd0 &&
        {win_pix0, win_pix1, win_pix2} === 24'd0) n_pass++;
    else $display("FAIL reset_outputs got=%b_%h required=0_0",
                  {win_val, win_sof, win_eof, win_sol, win_eol, err_ovf}, {win_pix0, win_pix1, win_pix2});
    n_checks++;
    if (pix_rdy === 1'b0) n_pass++; else $display("FAIL reset_pix_rdy_lo got=%b required=0", pix_rdy);
    win_rdy = 1'b1; #1;
    n_checks++;
    if (pix_rdy === 1'b1) n_pass++; else $display("FAIL reset_pix_rdy_hi got=%b required=1", pix_rdy);
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  // Stream a 4x3 frame back to back. This covers the border windows, the interior window and the markers.
  task automatic test_back_to_back();
    send_line(0, 4, 1'b1, 1'b0);
    send_line(1, 4, 1'b0, 1'b0);
    send_line(2, 4, 1'b0, 1'b1);
    go_idle();
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (exp_q.size() == 0 && err_ovf === 1'b0) n_pass++;
    else $display("FAIL frame_drain got=%0d/%b required=0/0", exp_q.size(), err_ovf);
  endtask

  // Stall the output for five cycles in the middle of row 1. Then check that no pixel is lost or repeated.
  task automatic test_stall();
    logic [31:0] snap;
    send_line(0, 4, 1'b1, 1'b0);
    drive_pix(8'd20, 1'b0, 1'b0, 1'b1, 1'b0, REPL ? 8'd10 : 8'd0, 8'd10);
    drive_pix(8'd21, 1'b0, 1'b0, 1'b0, 1'b0, REPL ? 8'd11 : 8'd0, 8'd11);
    win_rdy = 1'b0;
    pix_data = 8'd22; pix_sol = 1'b0; pix_eol = 1'b0; pix_val = 1'b1;
    exp_q.push_back({REPL ? 8'd12 : 8'd0, 8'd12, 8'd22, 4'b0000});
    snap = {win_pix0, win_pix1, win_pix2, win_sof, win_eof, win_sol, win_eol, win_val};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (pix_rdy === 1'b0 &&
          {win_pix0, win_pix1, win_pix2, win_sof, win_eof, win_sol, win_eol, win_val} === snap &&
          snap[0] === 1'b1) n_pass++;
      else $display("FAIL stall_hold cyc=%0d got=%h/%b required=%h/0",
                    i, {win_pix0, win_pix1, win_pix2, win_sof, win_eof, win_sol, win_eol, win_val},
                    pix_rdy, snap);
    end
    @(posedge clk); #1; win_rdy = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (win_val === 1'b1 && win_pix2 === 8'd22) n_pass++;
    else $display("FAIL stall_release got=%b/%0d required=1/22", win_val, win_pix2);
    drive_pix(8'd23, 1'b0, 1'b0, 1'b0, 1'b1, REPL ? 8'd13 : 8'd0, 8'd13);
    send_line(2, 4, 1'b0, 1'b1);
    go_idle();
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL stall_drain got=%0d required=0", exp_q.size());
  endtask

  // A line longer than MAX_LINE_W with no eol sets the sticky flag. The next sof clears it.
  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      o_pix_data = 8'(50 + i); o_pix_sof = (i == 0); o_pix_sol = (i == 0);
      o_pix_eol = 1'b0; o_pix_eof = 1'b0; o_pix_val = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (o_err_ovf === (i >= 3)) n_pass++;
      else $display("FAIL ovf_pix%0d got=%b required=%b", i, o_err_ovf, (i >= 3));
    end
    o_pix_data = 8'd60; o_pix_sof = 1'b1; o_pix_sol = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (o_err_ovf === 1'b0) n_pass++; else $display("FAIL ovf_clear got=%b required=0", o_err_ovf);
    o_pix_val = 1'b0; o_pix_sof = 1'b0; o_pix_sol = 1'b0;
  endtask

  // Assert reset asynchronously during row 2. The next frame starts at row 0 even without sof.
  task automatic test_midframe_reset();
    send_line(0, 4, 1'b1, 1'b0);
    send_line(1, 4, 1'b0, 1'b0);
    drive_pix(8'd30, 1'b0, 1'b0, 1'b1, 1'b0, 8'd10, 8'd20);
    drive_pix(8'd31, 1'b0, 1'b0, 1'b0, 1'b0, 8'd11, 8'd21);
    go_idle();
    @(negedge clk); #2;
    n_checks++;
    if (win_pix2 === 8'd31) n_pass++; else $display("FAIL pre_reset_pix2 got=%0d required=31", win_pix2);
    rst_n = 1'b0; #1;
    n_checks++;
    if ({win_val, win_sof, win_eof, win_sol, win_eol, err_ovf} === 6'd0 &&
        {win_pix0, win_pix1, win_pix2} === 24'd0) n_pass++;
    else $display("FAIL async_reset got=%b_%h required=0_0",
                  {win_val, win_sof, win_eof, win_sol, win_eol, err_ovf}, {win_pix0, win_pix1, win_pix2});
    exp_q.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    send_line(0, 4, 1'b0, 1'b0);
    send_line(1, 4, 1'b0, 1'b1);
    go_idle();
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++; else $display("FAIL post_reset_drain got=%0d required=0", exp_q.size());
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_midframe_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/median_line_buffer.md
MEDIAN_LINE_BUFFER -- requirements
Module: median_line_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 Parameter MAX_LINE_W, default 640: line-buffer depth in pixels, i.e. the maximum line width.
REQ-003 Parameter ADDR_W, default 10: column-counter width; must satisfy 2^ADDR_W >= MAX_LINE_W.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 pix_data  in  DATA_WIDTH  raster input pixel.
REQ-007 pix_val  in  1  input pixel valid.
REQ-008 pix_rdy  out  1  input ready.
REQ-009 pix_sol, pix_eol, pix_sof, pix_eof  in  1 each  start/end of line and frame markers, qualified by pix_val.
REQ-010 win_pix0  out  DATA_WIDTH  window pixel from two rows above the current pixel.
REQ-011 win_pix1  out  DATA_WIDTH  window pixel from one row above.
REQ-012 win_pix2  out  DATA_WIDTH  current-row pixel.
REQ-013 win_val  out  1  window valid.
REQ-014 win_rdy  in  1  downstream ready.
REQ-015 win_sol, win_eol, win_sof, win_eof  out  1 each  markers aligned to the window.
REQ-016 err_ovf  out  1  sticky line-overflow flag.

Function
REQ-017 The block SHALL drive pix_rdy combinationally equal to win_rdy.
REQ-018 An input transfer (acc) SHALL occur when pix_val & pix_rdy.
REQ-019 On acc, the block SHALL register win_pix2 <= pix_data, win_pix1 <= line1[col], win_pix0 <= line0[col], and SHALL load the four markers from the pix_* markers.
REQ-020 Latency SHALL be exactly one clock from acc to win_val=1.
REQ-021 On acc, the block SHALL write line0[col] <= line1[col] and line1[col] <= pix_data; the read of old contents and the write occur in the same cycle.
REQ-022 win_val update: SHALL set to 1 on acc; else SHALL clear to 0 when win_rdy & ~pix_val; else SHALL hold.
REQ-023 While win_val=1 and win_rdy=0, all win_* outputs SHALL hold stable.
REQ-024 col SHALL reset to 0 on acc with pix_sol=1 and SHALL otherwise increment by 1 per acc.
REQ-025 If col=MAX_LINE_W-1 and an acc occurs without pix_eol, col SHALL wrap to 0 and err_ovf SHALL set.
REQ-026 err_ovf SHALL clear only on an acc with pix_sof=1 or on reset.
REQ-027 row SHALL be a 2-bit counter saturating at 2.
REQ-028 On acc with pix_sof=1, row SHALL be set to 0 for that pixel.
REQ-029 row SHALL increment on acc with pix_eol=1.
REQ-030 sof and sol on the same pixel SHALL be legal; sof and eol on the same pixel SHALL be legal for a 1-pixel line.
REQ-031 For row 0 and row 1, the window contents SHALL follow REQ-039 or REQ-040.
REQ-032 For row 2 and later, the window SHALL be the true stored columns.
REQ-033 Line RAMs SHALL NOT be reset.

Reset
REQ-034 While rst_n=0, win_val, all four win_* markers, and err_ovf SHALL be 0.
REQ-035 While rst_n=0, win_pix0, win_pix1, win_pix2, col, and row SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL abort the frame.
REQ-037 After reset, the first acc SHALL be treated as row 0 regardless of pix_sof.
REQ-038 pix_rdy SHALL still follow win_rdy during reset.

Configuration
REQ-039 With macro MEDIAN_BORDER_REPL_EN defined, border replication SHALL apply: in row 0, win_pix0 = win_pix1 = pix_data; in row 1, win_pix0 = line1[col] and win_pix1 = line1[col].
REQ-040 Without MEDIAN_BORDER_REPL_EN, win_pix0 and win_pix1 SHALL be 0 in row 0, and win_pix0 SHALL be 0 in row 1; no replication logic SHALL be built.

Verification
REQ-041 4x3 frame, rows 10..13 / 20..23 / 30..33, win_rdy=1, macro on -> row-2 col-1 window (11,21,31); row-0 col-0 window (10,10,10); each output one cycle after its input.
REQ-042 Same frame, macro off -> row-0 window (0,0,10); row-1 col-2 window (0,12,22).
REQ-043 Hold win_rdy=0 for 5 cycles with win_val=1 -> pix_rdy=0, win_* stable, no RAM write; release -> no pixel lost or duplicated.
REQ-044 MAX_LINE_W=4, 6-pixel line without eol at pixel 4 -> err_ovf=1 after the 4th pixel; next sof -> err_ovf=0.
REQ-045 rst_n pulsed low mid-row 2 -> all outputs 0 asynchronously; next frame windows behave as row 0.
REQ-046 Markers: sof+sol on pixel 0 and eof+eol on the last pixel -> win_sof/win_sol and win_eof/win_eol asserted exactly on the corresponding window transfers.
